// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard receiver that turns arrow/WASD make and break codes into
// a held direction code plus one-cycle press and frame-error strobes.
//
// Ports:
//   clock, resetN    system clock, asynchronous active-low reset
//   ps2_clk, ps2_dat raw keyboard lines, asynchronous to clock
//   keyboard_input   held direction: 0 none, 1 up, 2 down, 3 left, 4 right
//   key_pressed      one-cycle strobe on a new direction press
//   frame_error      one-cycle strobe on parity, stop-bit or timeout failure
module ps2_direction_decoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [2:0] keyboard_input,
    output logic       key_pressed,
    output logic       frame_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        DEC_NORMAL,
        DEC_EXT,
        DEC_BRK,
        DEC_EXT_BRK
    } dec_state_t;

    logic clk_meta, clk_sync, clk_prev;
    logic dat_meta, dat_sync, dat_smp;
    logic fall;

    rx_state_t  rx_state, rx_next;
    dec_state_t dec_state, dec_next;

    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_ok;
    logic [TW-1:0] tcnt;

    logic       timeout;
    logic       byte_valid;
    logic       rx_err;
    logic       is_make;
    logic       is_brk;
    logic       use_ext;
    logic [2:0] dir;

    function automatic logic [2:0] ext_dir(input logic [7:0] code);
        case (code)
            8'h75:   return 3'd1;
            8'h72:   return 3'd2;
            8'h6B:   return 3'd3;
            8'h74:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] plain_dir(input logic [7:0] code);
        case (code)
            8'h1D:   return 3'd1;
            8'h1B:   return 3'd2;
            8'h1C:   return 3'd3;
            8'h23:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Data is delayed alongside the clock so dat_smp lines up with fall.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
            dat_smp  <= 1'b1;
            fall     <= 1'b0;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_dat;
            dat_sync <= dat_meta;
            dat_smp  <= dat_sync;
            fall     <= clk_prev & ~clk_sync;
        end
    end

    // An edge arriving on the expiry cycle wins over the timeout.
    assign timeout = (rx_state != RX_IDLE) && (tcnt == TMAX) && !fall;

    always_comb begin
        rx_next    = rx_state;
        byte_valid = 1'b0;
        rx_err     = 1'b0;
        if (timeout) begin
            rx_next = RX_IDLE;
            rx_err  = 1'b1;
        end else if (fall) begin
            unique case (rx_state)
                RX_IDLE: begin
                    if (!dat_smp)
                        rx_next = RX_DATA;
                end
                RX_DATA: begin
                    if (bit_cnt == 3'd7)
                        rx_next = RX_PARITY;
                end
                RX_PARITY: begin
                    rx_next = RX_STOP;
                end
                RX_STOP: begin
                    rx_next = RX_IDLE;
                    if (par_ok && dat_smp)
                        byte_valid = 1'b1;
                    else
                        rx_err = 1'b1;
                end
                default: rx_next = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rx_state <= RX_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_ok   <= 1'b0;
            tcnt     <= '0;
        end else begin
            rx_state <= rx_next;
            if (rx_state == RX_IDLE || fall)
                tcnt <= '0;
            else if (tcnt != TMAX)
                tcnt <= tcnt + 1'b1;
            if (fall) begin
                unique case (rx_state)
                    RX_IDLE: begin
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end
                    RX_DATA: begin
                        shreg[bit_cnt] <= dat_smp;
                        bit_cnt        <= bit_cnt + 3'd1;
                    end
                    RX_PARITY: par_ok <= ^{shreg, dat_smp};
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        dec_next = dec_state;
        is_make  = 1'b0;
        is_brk   = 1'b0;
        use_ext  = 1'b0;
        if (rx_err) begin
            dec_next = DEC_NORMAL;
        end else if (byte_valid) begin
            unique case (dec_state)
                DEC_NORMAL: begin
                    if (shreg == 8'hE0)
                        dec_next = DEC_EXT;
                    else if (shreg == 8'hF0)
                        dec_next = DEC_BRK;
                    else
                        is_make = 1'b1;
                end
                DEC_EXT: begin
                    if (shreg == 8'hF0) begin
                        dec_next = DEC_EXT_BRK;
                    end else begin
                        is_make  = 1'b1;
                        use_ext  = 1'b1;
                        dec_next = DEC_NORMAL;
                    end
                end
                DEC_BRK: begin
                    is_brk   = 1'b1;
                    dec_next = DEC_NORMAL;
                end
                DEC_EXT_BRK: begin
                    is_brk   = 1'b1;
                    use_ext  = 1'b1;
                    dec_next = DEC_NORMAL;
                end
                default: dec_next = DEC_NORMAL;
            endcase
        end
    end

    assign dir = use_ext ? ext_dir(shreg) : plain_dir(shreg);

    // Repeats of the held key and breaks of other keys leave the output alone.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            dec_state      <= DEC_NORMAL;
            keyboard_input <= 3'd0;
            key_pressed    <= 1'b0;
        end else begin
            dec_state   <= dec_next;
            key_pressed <= 1'b0;
            if (is_make && dir != 3'd0 && dir != keyboard_input) begin
                keyboard_input <= dir;
                key_pressed    <= 1'b1;
            end else if (is_brk && dir != 3'd0 && dir == keyboard_input) begin
                keyboard_input <= 3'd0;
            end
        end
    end

    assign frame_error = rx_err;

endmodule
